// File: rtl/board_update.sv
// Authoritative chess board state for both sides: 6-bit square and alive flag per piece.
// A confirmed move request (rising edge of en) relocates one piece of the latched side,
// clears any opposing piece found on the target square, and hands the turn over.
// Ports:
//   clk, RST (sync, active-high)
//   en, player, move_input[5:0] {y,x}, piece_number[3:0]   move request
//   location_vectors_w/b[95:0]   piece i square at [6i+5:6i]
//   alive_vectors_w/b[15:0]      bit i set while piece i is on the board
//   dbg_state[1:0]               IDLE=0, SCAN=1, UPDATE=2, DONE=3
//   output_player                side to move next
//   done                         one-cycle completion pulse
module board_update (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic        player,
  input  logic [5:0]  move_input,
  input  logic [3:0]  piece_number,
  output logic [95:0] location_vectors_w,
  output logic [95:0] location_vectors_b,
  output logic [15:0] alive_vectors_w,
  output logic [15:0] alive_vectors_b,
  output logic [1:0]  dbg_state,
  output logic        output_player,
  output logic        done
);

  localparam int unsigned NUM_PIECES = 16;
  localparam int unsigned SQ_W       = 6;
  localparam int unsigned VEC_W      = NUM_PIECES * SQ_W;
  localparam int unsigned ID_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bit offset of piece p inside a location vector (6*p).
  function automatic logic [6:0] sq_base(input logic [ID_W-1:0] p);
    return 7'({p, 2'b00}) + 7'({p, 1'b0});
  endfunction

  // Start-position location vector for one side.
  function automatic logic [VEC_W-1:0] start_loc(input logic black);
    logic [VEC_W-1:0] v;
    logic [2:0]       x;
    logic [2:0]       y;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        x = 3'(i);
        y = black ? 3'd6 : 3'd1;
      end else begin
        case (i)
          8:       x = 3'd0;
          9:       x = 3'd7;
          10:      x = 3'd1;
          11:      x = 3'd6;
          12:      x = 3'd2;
          13:      x = 3'd5;
          14:      x = 3'd3;
          default: x = 3'd4;
        endcase
        y = black ? 3'd7 : 3'd0;
      end
      v[i*6 +: 6] = {y, x};
    end
    return v;
  endfunction

  state_e                  state_q, state_d;
  logic                    en_q, en_d;
  logic                    rise_q, rise_d;
  logic                    lat_player_q, lat_player_d;
  logic [ID_W-1:0]         lat_piece_q, lat_piece_d;
  logic [SQ_W-1:0]         lat_target_q, lat_target_d;
  logic [ID_W-1:0]         k_q, k_d;
  logic [VEC_W-1:0]        loc_w_q, loc_w_d;
  logic [VEC_W-1:0]        loc_b_q, loc_b_d;
  logic [NUM_PIECES-1:0]   alive_w_q, alive_w_d;
  logic [NUM_PIECES-1:0]   alive_b_q, alive_b_d;
  logic                    player_q, player_d;
  logic                    done_q, done_d;

  logic                    accept_c;
  logic [6:0]              scan_base_c;
  logic [6:0]              mover_base_c;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      rise_q       <= 1'b0;
      lat_player_q <= 1'b0;
      lat_piece_q  <= '0;
      lat_target_q <= '0;
      k_q          <= '0;
      loc_w_q      <= start_loc(1'b0);
      loc_b_q      <= start_loc(1'b1);
      alive_w_q    <= '1;
      alive_b_q    <= '1;
      player_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      rise_q       <= rise_d;
      lat_player_q <= lat_player_d;
      lat_piece_q  <= lat_piece_d;
      lat_target_q <= lat_target_d;
      k_q          <= k_d;
      loc_w_q      <= loc_w_d;
      loc_b_q      <= loc_b_d;
      alive_w_q    <= alive_w_d;
      alive_b_q    <= alive_b_d;
      player_q     <= player_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise_q) state_d = SCAN;
      SCAN:    if (k_q == 4'd15) state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    // Edges seen outside IDLE are dropped rather than queued.
    accept_c     = en & ~en_q & (state_q == IDLE);
    scan_base_c  = sq_base(k_q);
    mover_base_c = sq_base(lat_piece_q);

    en_d         = en;
    rise_d       = accept_c;
    lat_player_d = lat_player_q;
    lat_piece_d  = lat_piece_q;
    lat_target_d = lat_target_q;
    k_d          = k_q;
    loc_w_d      = loc_w_q;
    loc_b_d      = loc_b_q;
    alive_w_d    = alive_w_q;
    alive_b_d    = alive_b_q;
    player_d     = player_q;
    done_d       = (state_d == DONE);

    if (accept_c) begin
      lat_player_d = player;
      lat_piece_d  = piece_number;
      lat_target_d = move_input;
    end

    case (state_q)
      IDLE: k_d = '0;
      SCAN: begin
        k_d = k_q + 4'd1;
        // One opponent per cycle; a captured piece keeps its last square.
        if (!lat_player_q) begin
          if (alive_b_q[k_q] && (loc_b_q[scan_base_c +: SQ_W] == lat_target_q))
            alive_b_d[k_q] = 1'b0;
        end else begin
          if (alive_w_q[k_q] && (loc_w_q[scan_base_c +: SQ_W] == lat_target_q))
            alive_w_d[k_q] = 1'b0;
        end
      end
      UPDATE: begin
        // A dead mover changes nothing and does not pass the turn.
        if (!lat_player_q) begin
          if (alive_w_q[lat_piece_q]) begin
            loc_w_d[mover_base_c +: SQ_W] = lat_target_q;
            player_d = ~player_q;
          end
        end else begin
          if (alive_b_q[lat_piece_q]) begin
            loc_b_d[mover_base_c +: SQ_W] = lat_target_q;
            player_d = ~player_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign location_vectors_w = loc_w_q;
  assign location_vectors_b = loc_b_q;
  assign alive_vectors_w    = alive_w_q;
  assign alive_vectors_b    = alive_b_q;
  assign dbg_state          = state_q;
  assign output_player      = player_q;
  assign done               = done_q;

endmodule

// File: tb/tb_board_update.sv
// Directed bench for board_update: start position, move timing, capture,
// held/re-triggered en, dead-piece move and mid-scan reset.
module tb_board_update;

  logic        clk;
  logic        RST;
  logic        en;
  logic        player;
  logic [5:0]  move_input;
  logic [3:0]  piece_number;
  logic [95:0] location_vectors_w;
  logic [95:0] location_vectors_b;
  logic [15:0] alive_vectors_w;
  logic [15:0] alive_vectors_b;
  logic [1:0]  dbg_state;
  logic        output_player;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] start_w;
  logic [95:0] start_b;
  logic [95:0] exp_lw;
  logic [95:0] exp_lb;
  logic [15:0] exp_aw;
  logic [15:0] exp_ab;
  int          d_at;
  int          d_cnt;

  board_update dut (
    .clk                (clk),
    .RST                (RST),
    .en                 (en),
    .player             (player),
    .move_input         (move_input),
    .piece_number       (piece_number),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .dbg_state          (dbg_state),
    .output_player      (output_player),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one move (single en pulse) and watch 30 cycles after the sampling edge.
  task automatic do_move(input logic p, input logic [3:0] pc, input logic [5:0] tgt,
                         output int at, output int cnt);
    @(negedge clk);
    player = p; piece_number = pc; move_input = tgt; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    at = 0; cnt = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cnt++;
        if (at == 0) at = j;
      end
    end
  endtask

  task automatic check_board(input string tag);
    check({tag, "_lw"}, location_vectors_w, exp_lw);
    check({tag, "_lb"}, location_vectors_b, exp_lb);
    check({tag, "_aw"}, 96'(alive_vectors_w), 96'(exp_aw));
    check({tag, "_ab"}, 96'(alive_vectors_b), 96'(exp_ab));
  endtask

  initial begin
    start_w = {6'o04, 6'o03, 6'o05, 6'o02, 6'o06, 6'o01, 6'o07, 6'o00,
               6'o17, 6'o16, 6'o15, 6'o14, 6'o13, 6'o12, 6'o11, 6'o10};
    start_b = {6'o74, 6'o73, 6'o75, 6'o72, 6'o76, 6'o71, 6'o77, 6'o70,
               6'o67, 6'o66, 6'o65, 6'o64, 6'o63, 6'o62, 6'o61, 6'o60};
    exp_lw = start_w; exp_lb = start_b; exp_aw = 16'hFFFF; exp_ab = 16'hFFFF;

    RST = 1'b1; en = 1'b0; player = 1'b0; move_input = '0; piece_number = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;

    // Reset state
    check_board("rst");
    check("rst_lw0", 96'(location_vectors_w[5:0]), 96'(6'o10));
    check("rst_lw15", 96'(location_vectors_w[95:90]), 96'(6'o04));
    check("rst_lb15", 96'(location_vectors_b[95:90]), 96'(6'o74));
    check("rst_player", 96'(output_player), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_state", 96'(dbg_state), 96'(0));

    // White pawn 4 to e4-ish square 6'o34
    do_move(1'b0, 4'd4, 6'o34, d_at, d_cnt);
    exp_lw[29:24] = 6'o34;
    check("m1_done_at", 96'(d_at), 96'(18));
    check("m1_done_cnt", 96'(d_cnt), 96'(1));
    check_board("m1");
    check("m1_player", 96'(output_player), 96'(1));
    check("m1_state", 96'(dbg_state), 96'(0));

    // White pawn 3 to 6'o53, then captures black pawn 3 on 6'o63
    do_move(1'b0, 4'd3, 6'o53, d_at, d_cnt);
    exp_lw[23:18] = 6'o53;
    check("m2_done_cnt", 96'(d_cnt), 96'(1));
    check_board("m2");
    check("m2_player", 96'(output_player), 96'(0));

    do_move(1'b0, 4'd3, 6'o63, d_at, d_cnt);
    exp_lw[23:18] = 6'o63;
    exp_ab[3] = 1'b0;
    check("cap_done_at", 96'(d_at), 96'(18));
    check_board("cap");
    check("cap_lb3", 96'(location_vectors_b[23:18]), 96'(6'o63));
    check("cap_player", 96'(output_player), 96'(1));

    // en held high for 40 cycles: black rook 8 to 6'o50, exactly one move
    @(negedge clk);
    player = 1'b1; piece_number = 4'd8; move_input = 6'o50; en = 1'b1;
    d_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) d_cnt++;
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    exp_lb[53:48] = 6'o50;
    check("hold_done_cnt", 96'(d_cnt), 96'(1));
    check_board("hold");
    check("hold_player", 96'(output_player), 96'(0));

    // Second en edge during SCAN (with different request) must be ignored
    @(negedge clk);
    player = 1'b1; piece_number = 4'd1; move_input = 6'o51; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    d_cnt = 0;
    for (int j = 1; j <= 35; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) d_cnt++;
      if (j == 3) begin
        piece_number = 4'd2; move_input = 6'o52; en = 1'b1;
      end
      if (j == 5) en = 1'b0;
    end
    exp_lb[11:6] = 6'o51;
    check("edge2_done_cnt", 96'(d_cnt), 96'(1));
    check_board("edge2");
    check("edge2_lb2", 96'(location_vectors_b[17:12]), 96'(6'o62));
    check("edge2_player", 96'(output_player), 96'(1));

    // Captured black pawn 3 tries to move: done pulses, nothing else changes
    do_move(1'b1, 4'd3, 6'o40, d_at, d_cnt);
    check("dead_done_at", 96'(d_at), 96'(18));
    check("dead_done_cnt", 96'(d_cnt), 96'(1));
    check_board("dead");
    check("dead_player", 96'(output_player), 96'(1));

    // Reset in the middle of SCAN aborts the move with no partial update
    @(negedge clk);
    player = 1'b0; piece_number = 4'd0; move_input = 6'o20; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_state", 96'(dbg_state), 96'(1));
    RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    exp_lw = start_w; exp_lb = start_b; exp_aw = 16'hFFFF; exp_ab = 16'hFFFF;
    check_board("abort");
    check("abort_player", 96'(output_player), 96'(0));
    check("abort_state", 96'(dbg_state), 96'(0));
    check("abort_done", 96'(done), 96'(0));
    d_cnt = 0;
    for (int j = 0; j < 25; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) d_cnt++;
    end
    check("abort_no_done", 96'(d_cnt), 96'(0));
    check_board("abort_late");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
